hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
Parametrised successor to the 5-stage pipeline hazard unit. It generates operand forwarding selects for a configurable number of execute-stage source operands, load-use stalls and branch flushes. It adds a sequential scoreboard for one multi-cycle functional unit (e.g. mul/div) with variable latency. It sits between the D/E/M/W pipeline registers and the PC register and drives their stall and flush inputs.

Parameters:
ADDR_WIDTH, 5, register address width
NUM_REGS, 32, architectural registers tracked (2**ADDR_WIDTH)
NUM_SRC, 2, source operands per instruction (forward mux count)
LAT_WIDTH, 3, width of long-op latency field; max latency 2**LAT_WIDTH-1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
Rs_D  in  NUM_SRC*ADDR_WIDTH  decode-stage source addresses, packed, src0 in LSBs
Rs_E  in  NUM_SRC*ADDR_WIDTH  execute-stage source addresses
RdE  in  ADDR_WIDTH  execute-stage destination
RdM  in  ADDR_WIDTH  memory-stage destination
RdW  in  ADDR_WIDTH  writeback-stage destination
RegWriteM  in  1  M-stage instruction writes Rd
RegWriteW  in  1  W-stage instruction writes Rd
ResultSrcE0  in  1  E-stage instruction is a load
PCSrcE  in  1  branch/jump taken in E
LongOpD  in  1  D-stage instruction targets the multi-cycle unit
LongIssueE  in  1  E-stage long op issues this cycle
LongLatE  in  LAT_WIDTH  latency of issuing op, cycles, >=1
ForwardE  out  NUM_SRC*2  per-source select: 00 register file, 10 ALUResultM, 01 ResultW
StallF  out  1  hold PC register
StallD  out  1  hold F/D register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
LongBusy  out  1  long unit occupied
LongDone  out  1  one-cycle pulse: long result valid for writeback

Behaviour:
- Forwarding is combinational, per source i. If RegWriteM, RdM!=0 and Rs_E[i]==RdM, select 10. Else if RegWriteW, RdW!=0 and Rs_E[i]==RdW, select 01. Else select 00. M has priority over W.
- lwStall: ResultSrcE0 and RdE!=0 and any Rs_D[i]==RdE.
- Scoreboard state: busy[NUM_REGS], cnt[LAT_WIDTH], rd_q[ADDR_WIDTH], FSM {IDLE, BUSY}.
- IDLE -> BUSY on LongIssueE. Load cnt=LongLatE-1, rd_q=RdE, set busy[RdE] unless RdE==0.
- BUSY: decrement cnt each cycle. LongDone=1 combinationally while BUSY and cnt==0. On that edge clear busy[rd_q] and return to IDLE. If LongIssueE is asserted in the same cycle, reload instead (back-to-back issue accepted). The new busy bit wins if rd_q equals the new RdE.
- LongLatE=1: LongDone asserts in the cycle after issue.
- LongLatE==0 is illegal: treat as 1.
- longStall is asserted if any of the following holds:
  - any Rs_D[i]!=0 with busy[Rs_D[i]];
  - LongIssueE and RdE!=0 and any Rs_D[i]==RdE;
  - LongOpD and (LongIssueE or (BUSY and cnt!=0)).
- Outputs:
  - stall = lwStall | longStall;
  - StallF = StallD = stall & ~PCSrcE;
  - FlushD = PCSrcE;
  - FlushE = stall | PCSrcE.
  - Branch redirect wins over stall.
- Register x0 is never busy, never forwarded and never stalls.
- Reset: FSM=IDLE, busy=0, cnt=0, rd_q=0. While rst is high, the outputs are forced to:
  - ForwardE=0, StallF=StallD=0;
  - FlushD=FlushE=1;
  - LongBusy=0, LongDone=0.
- Reset mid-operation abandons the in-flight op; no LongDone pulse is produced.
- LongBusy = (state==BUSY).

Decomposition:
- Shared package pipeline_pkg holds:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10};
  - lsb_state_t enum {LS_IDLE, LS_BUSY};
  - constant REG_ZERO.
- One natural sub-module: long_op_tracker (FSM, cnt, rd_q, busy vector). It exports busy vector, LongBusy, LongDone and cnt_nz.
- Forwarding, stall and flush logic stays combinational in the top.

Test Plan:
- RAW forwarding: Rs_E[0]=5; RdM=5 and RdW=5, both with RegWrite -> ForwardE[1:0]=10. Deassert RegWriteM -> 01. Use Rs_E=0 with RdM=0 -> 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs_D[1]=7 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle. Next cycle, with the load in M -> no stall, ForwardE[3:2]=10.
- Long op latency 4, RdE=9:
  - LongBusy is high for 4 cycles after the issue edge.
  - LongDone pulses in the 4th cycle.
  - A dependent Rs_D=9 stalls for exactly those cycles plus the issue cycle.
  - busy[9] is clear afterwards.
- Structural and back-to-back: LongOpD asserted while BUSY with cnt=2 -> stall. A second LongIssueE in the LongDone cycle -> FSM stays BUSY with the new latency and no idle gap.
- Branch versus stall: lwStall condition with PCSrcE=1 in the same cycle -> StallF=StallD=0, FlushD=FlushE=1.
- Reset mid-op: issue latency 7, assert rst on cycle 3 -> the next cycle shows LongBusy=0, busy all zero, no LongDone pulse, and a dependent Rs_D does not stall.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the hazard scoreboard slice.
// Holds the forwarding-select encoding, the long-op tracker state
// encoding and the architectural zero register index.
package pipeline_pkg;

  // Forward mux select: register file, writeback result, or ALU result in M
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Long-op tracker occupancy
  typedef enum logic {
    LS_IDLE = 1'b0,
    LS_BUSY = 1'b1
  } lsb_state_t;

  // x0 is hardwired to zero: never busy, never forwarded, never stalls
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/long_op_tracker.sv
// Scoreboard for one multi-cycle functional unit with variable latency.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   issue         a long op issues from E this cycle
//   lat           latency of the issuing op in cycles (0 is treated as 1)
//   rd            destination register of the issuing op
//   busy          per-register pending-write flags (bit 0 never set)
//   longBusy      unit occupied
//   longDone      result valid for writeback this cycle
//   cntNz         remaining-cycle counter is non-zero
module long_op_tracker
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int LAT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic [LAT_WIDTH-1:0]  lat,
  input  logic [ADDR_WIDTH-1:0] rd,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  longBusy,
  output logic                  longDone,
  output logic                  cntNz
);

  lsb_state_t            state, stateNext;
  logic [LAT_WIDTH-1:0]  cnt, cntNext, latEff;
  logic [ADDR_WIDTH-1:0] rdQ, rdQNext;
  logic [NUM_REGS-1:0]   busyNext;
  logic                  accept;

  assign longBusy = (state == LS_BUSY);
  assign cntNz    = (cnt != '0);

  // State register: reset abandons any in-flight op and clears the scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LS_IDLE;
      cnt   <= '0;
      rdQ   <= '0;
      busy  <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      rdQ   <= rdQNext;
      busy  <= busyNext;
    end
  end

  // Next-state logic. The busy bit of the finishing op is cleared before the
  // new op's bit is set, so a back-to-back issue to the same register keeps
  // it marked busy. An issue is only accepted when idle or in the done cycle.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    rdQNext   = rdQ;
    busyNext  = busy;
    longDone  = 1'b0;
    accept    = 1'b0;
    latEff    = (lat == '0) ? LAT_WIDTH'(1) : lat;
    case (state)
      LS_IDLE: accept = issue;
      LS_BUSY: begin
        if (cnt == '0) begin
          longDone       = 1'b1;
          busyNext[rdQ]  = 1'b0;
          stateNext      = LS_IDLE;
          accept         = issue;
        end else begin
          cntNext = cnt - LAT_WIDTH'(1);
        end
      end
    endcase
    if (accept) begin
      stateNext = LS_BUSY;
      cntNext   = latEff - LAT_WIDTH'(1);
      rdQNext   = rd;
      if (rd != ADDR_WIDTH'(REG_ZERO)) begin
        busyNext[rd] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use stalls, branch flushes
// and a scoreboard for one variable-latency multi-cycle unit.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   Rs_D, Rs_E           packed source addresses in D and E (src0 in LSBs)
//   RdE, RdM, RdW        destinations in E, M, W
//   RegWriteM/W          M/W instruction writes its destination
//   ResultSrcE0          E instruction is a load
//   PCSrcE               branch/jump taken in E
//   LongOpD              D instruction targets the multi-cycle unit
//   LongIssueE, LongLatE long op issues from E with the given latency
//   ForwardE             per-source forward select (2 bits each)
//   StallF/StallD        hold PC and F/D registers
//   FlushD/FlushE        clear F/D and D/E registers
//   LongBusy, LongDone   multi-cycle unit occupied / result valid
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int NUM_SRC    = 2,
  parameter int LAT_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] Rs_D,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] Rs_E,
  input  logic [ADDR_WIDTH-1:0]         RdE,
  input  logic [ADDR_WIDTH-1:0]         RdM,
  input  logic [ADDR_WIDTH-1:0]         RdW,
  input  logic                          RegWriteM,
  input  logic                          RegWriteW,
  input  logic                          ResultSrcE0,
  input  logic                          PCSrcE,
  input  logic                          LongOpD,
  input  logic                          LongIssueE,
  input  logic [LAT_WIDTH-1:0]          LongLatE,
  output logic [NUM_SRC*2-1:0]          ForwardE,
  output logic                          StallF,
  output logic                          StallD,
  output logic                          FlushD,
  output logic                          FlushE,
  output logic                          LongBusy,
  output logic                          LongDone
);

  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REGS-1:0]   busy;
  logic                  trackBusy, trackDone, cntNz;
  logic                  lwStall, longStall, stall;
  logic [ADDR_WIDTH-1:0] rsD, rsE;

  long_op_tracker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .LAT_WIDTH (LAT_WIDTH)
  ) tracker (
    .clk     (clk),
    .rst     (rst),
    .issue   (LongIssueE),
    .lat     (LongLatE),
    .rd      (RdE),
    .busy    (busy),
    .longBusy(trackBusy),
    .longDone(trackDone),
    .cntNz   (cntNz)
  );

  // Forwarding, stall detection and flush control. M forwarding takes
  // priority over W since it is the younger write. A taken branch kills the
  // instructions a stall would hold, so redirect overrides stall. While in
  // reset the pipeline registers are flushed and everything else is quiet.
  always_comb begin
    ForwardE  = '0;
    lwStall   = 1'b0;
    longStall = 1'b0;
    rsD       = '0;
    rsE       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rsD = Rs_D[i*ADDR_WIDTH +: ADDR_WIDTH];
      rsE = Rs_E[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (RegWriteM && RdM != ZERO && rsE == RdM) begin
        ForwardE[i*2 +: 2] = FWD_M;
      end else if (RegWriteW && RdW != ZERO && rsE == RdW) begin
        ForwardE[i*2 +: 2] = FWD_W;
      end
      if (ResultSrcE0 && RdE != ZERO && rsD == RdE) begin
        lwStall = 1'b1;
      end
      if (rsD != ZERO && busy[rsD]) begin
        longStall = 1'b1;
      end
      if (LongIssueE && RdE != ZERO && rsD == RdE) begin
        longStall = 1'b1;
      end
    end
    if (LongOpD && (LongIssueE || (trackBusy && cntNz))) begin
      longStall = 1'b1;
    end
    stall    = lwStall | longStall;
    StallF   = stall & ~PCSrcE;
    StallD   = stall & ~PCSrcE;
    FlushD   = PCSrcE;
    FlushE   = stall | PCSrcE;
    LongBusy = trackBusy;
    LongDone = trackDone;
    if (rst) begin
      ForwardE = '0;
      StallF   = 1'b0;
      StallD   = 1'b0;
      FlushD   = 1'b1;
      FlushE   = 1'b1;
      LongBusy = 1'b0;
      LongDone = 1'b0;
    end
  end

endmodule
